// File: rtl/cache_ctrl_nway.sv
// N-way set-associative cache controller: hit/miss sequencing, write-back and
// line fill over a handshaked memory port, full-cache flush walker, wait timeout.
module cache_ctrl_nway #(
  parameter int unsigned WAYS    = 2,
  parameter int unsigned SETS    = 16,
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned WAY_W  = $clog2(WAYS),
  localparam int unsigned SET_W  = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_read,
  input  logic             cpu_write,
  input  logic             hit,
  input  logic [WAY_W-1:0] hit_way,
  input  logic [WAYS-1:0]  is_valid,
  input  logic [WAYS-1:0]  is_dirty,
  input  logic [WAY_W-1:0] victim_way,
  input  logic             mem_resp,
  input  logic             flush,
  output logic             cpu_mem_valid,
  output logic             lru_load,
  output logic             mem_read,
  output logic             mem_write,
  output logic             data_in_select,
  output logic             error,
  output logic             flush_busy,
  output logic             flush_done,
  output logic [WAY_W-1:0] lru_way,
  output logic [WAY_W-1:0] flush_way,
  output logic [SET_W-1:0] flush_set,
  output logic [WAYS-1:0]  load_data_bytes,
  output logic [WAYS-1:0]  load_data_lines,
  output logic [WAYS-1:0]  load_tag,
  output logic [WAYS-1:0]  set_dirty,
  output logic [WAYS-1:0]  write_dirty,
  output logic [WAYS-1:0]  set_valid,
  output logic [WAYS-1:0]  write_valid
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE, CHECK, WB_REQ, FILL_REQ, INSTALL, FL_SCAN, FL_WB, ERROR
  } state_t;

  state_t           state_q, state_d;
  logic             op_write_q, op_write_d;
  logic [WAY_W-1:0] vway_q, vway_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             fl_skip_q, fl_skip_d;
  logic [SET_W-1:0] flush_set_q, flush_set_d;
  logic [WAY_W-1:0] flush_way_q, flush_way_d;

  logic             cpu_mem_valid_q, cpu_mem_valid_d;
  logic             lru_load_q, lru_load_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic             data_in_select_q, data_in_select_d;
  logic             error_q, error_d;
  logic             flush_busy_q, flush_busy_d;
  logic             flush_done_q, flush_done_d;
  logic [WAY_W-1:0] lru_way_q, lru_way_d;
  logic [WAYS-1:0]  load_data_bytes_q, load_data_bytes_d;
  logic [WAYS-1:0]  load_data_lines_q, load_data_lines_d;
  logic [WAYS-1:0]  load_tag_q, load_tag_d;
  logic [WAYS-1:0]  set_dirty_q, set_dirty_d;
  logic [WAYS-1:0]  write_dirty_q, write_dirty_d;
  logic [WAYS-1:0]  set_valid_q, set_valid_d;
  logic [WAYS-1:0]  write_valid_q, write_valid_d;

  logic             free_found;
  logic [WAY_W-1:0] free_way;
  logic [WAY_W-1:0] miss_way;
  logic [WAYS-1:0]  hit_oh, vway_oh, fway_oh;
  logic             hit_ok, miss_dirty, flush_dirty, flush_last, wait_expired;

  // Lowest-index invalid way wins over the LRU victim on a miss.
  always_comb begin
    free_found = 1'b0;
    free_way   = '0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (!is_valid[i]) begin
        free_found = 1'b1;
        free_way   = WAY_W'(i);
      end
    end
  end

  assign miss_way     = free_found ? free_way : victim_way;
  assign hit_ok       = hit && is_valid[hit_way];
  assign miss_dirty   = is_valid[miss_way] && is_dirty[miss_way];
  assign flush_dirty  = is_valid[flush_way_q] && is_dirty[flush_way_q];
  assign flush_last   = (flush_set_q == SET_W'(SETS - 1)) && (flush_way_q == WAY_W'(WAYS - 1));
  assign wait_expired = (wait_q == CNT_W'(TIMEOUT - 1));
  assign hit_oh       = WAYS'(1) << hit_way;
  assign vway_oh      = WAYS'(1) << vway_q;
  assign fway_oh      = WAYS'(1) << flush_way_q;

  // Outputs are computed for the state being entered, so they line up with it.
  always_comb begin
    state_d           = state_q;
    op_write_d        = op_write_q;
    vway_d            = vway_q;
    wait_d            = wait_q;
    fl_skip_d         = 1'b0;
    flush_set_d       = flush_set_q;
    flush_way_d       = flush_way_q;
    cpu_mem_valid_d   = 1'b0;
    lru_load_d        = 1'b0;
    mem_read_d        = 1'b0;
    mem_write_d       = 1'b0;
    data_in_select_d  = 1'b0;
    error_d           = 1'b0;
    flush_busy_d      = 1'b0;
    flush_done_d      = 1'b0;
    lru_way_d         = '0;
    load_data_bytes_d = '0;
    load_data_lines_d = '0;
    load_tag_d        = '0;
    set_dirty_d       = '0;
    write_dirty_d     = '0;
    set_valid_d       = '0;
    write_valid_d     = '0;

    case (state_q)
      IDLE: begin
        // Requests are held until acknowledged; skip the ack cycle itself.
        if (!cpu_mem_valid_q && !flush_done_q) begin
          if (flush) begin
            state_d      = FL_SCAN;
            flush_set_d  = '0;
            flush_way_d  = '0;
            flush_busy_d = 1'b1;
          end else if (cpu_write || cpu_read) begin
            state_d    = CHECK;
            op_write_d = cpu_write;
          end
        end
      end
      CHECK: begin
        if (hit_ok) begin
          state_d         = IDLE;
          cpu_mem_valid_d = 1'b1;
          lru_load_d      = 1'b1;
          lru_way_d       = hit_way;
          if (op_write_q) begin
            load_data_bytes_d = hit_oh;
            write_dirty_d     = hit_oh;
            set_dirty_d       = hit_oh;
          end
        end else begin
          vway_d = miss_way;
          wait_d = '0;
          if (miss_dirty) begin
            state_d     = WB_REQ;
            mem_write_d = 1'b1;
          end else begin
            state_d    = FILL_REQ;
            mem_read_d = 1'b1;
          end
        end
      end
      WB_REQ: begin
        if (mem_resp) begin
          state_d    = FILL_REQ;
          wait_d     = '0;
          mem_read_d = 1'b1;
        end else if (wait_expired) begin
          state_d = ERROR;
          error_d = 1'b1;
        end else begin
          wait_d      = wait_q + 1'b1;
          mem_write_d = 1'b1;
        end
      end
      FILL_REQ: begin
        if (mem_resp) begin
          state_d           = INSTALL;
          data_in_select_d  = 1'b1;
          load_data_lines_d = vway_oh;
          load_tag_d        = vway_oh;
          write_valid_d     = vway_oh;
          set_valid_d       = vway_oh;
          write_dirty_d     = vway_oh;
        end else if (wait_expired) begin
          state_d = ERROR;
          error_d = 1'b1;
        end else begin
          wait_d     = wait_q + 1'b1;
          mem_read_d = 1'b1;
        end
      end
      INSTALL: state_d = CHECK;
      FL_SCAN: begin
        // fl_skip_q marks the cycle carrying the dirty-clear strobe for this slot.
        if (!fl_skip_q && flush_dirty) begin
          state_d      = FL_WB;
          wait_d       = '0;
          flush_busy_d = 1'b1;
          mem_write_d  = 1'b1;
        end else if (flush_last) begin
          state_d      = IDLE;
          flush_done_d = 1'b1;
          flush_set_d  = '0;
          flush_way_d  = '0;
        end else begin
          flush_busy_d = 1'b1;
          flush_way_d  = flush_way_q + 1'b1;
          if (flush_way_q == WAY_W'(WAYS - 1)) flush_set_d = flush_set_q + 1'b1;
        end
      end
      FL_WB: begin
        if (mem_resp) begin
          state_d       = FL_SCAN;
          fl_skip_d     = 1'b1;
          flush_busy_d  = 1'b1;
          write_dirty_d = fway_oh;
        end else if (wait_expired) begin
          state_d = ERROR;
          error_d = 1'b1;
        end else begin
          wait_d       = wait_q + 1'b1;
          flush_busy_d = 1'b1;
          mem_write_d  = 1'b1;
        end
      end
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= IDLE;
      op_write_q        <= 1'b0;
      vway_q            <= '0;
      wait_q            <= '0;
      fl_skip_q         <= 1'b0;
      flush_set_q       <= '0;
      flush_way_q       <= '0;
      cpu_mem_valid_q   <= 1'b0;
      lru_load_q        <= 1'b0;
      mem_read_q        <= 1'b0;
      mem_write_q       <= 1'b0;
      data_in_select_q  <= 1'b0;
      error_q           <= 1'b0;
      flush_busy_q      <= 1'b0;
      flush_done_q      <= 1'b0;
      lru_way_q         <= '0;
      load_data_bytes_q <= '0;
      load_data_lines_q <= '0;
      load_tag_q        <= '0;
      set_dirty_q       <= '0;
      write_dirty_q     <= '0;
      set_valid_q       <= '0;
      write_valid_q     <= '0;
    end else begin
      state_q           <= state_d;
      op_write_q        <= op_write_d;
      vway_q            <= vway_d;
      wait_q            <= wait_d;
      fl_skip_q         <= fl_skip_d;
      flush_set_q       <= flush_set_d;
      flush_way_q       <= flush_way_d;
      cpu_mem_valid_q   <= cpu_mem_valid_d;
      lru_load_q        <= lru_load_d;
      mem_read_q        <= mem_read_d;
      mem_write_q       <= mem_write_d;
      data_in_select_q  <= data_in_select_d;
      error_q           <= error_d;
      flush_busy_q      <= flush_busy_d;
      flush_done_q      <= flush_done_d;
      lru_way_q         <= lru_way_d;
      load_data_bytes_q <= load_data_bytes_d;
      load_data_lines_q <= load_data_lines_d;
      load_tag_q        <= load_tag_d;
      set_dirty_q       <= set_dirty_d;
      write_dirty_q     <= write_dirty_d;
      set_valid_q       <= set_valid_d;
      write_valid_q     <= write_valid_d;
    end
  end

  assign cpu_mem_valid   = cpu_mem_valid_q;
  assign lru_load        = lru_load_q;
  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign data_in_select  = data_in_select_q;
  assign error           = error_q;
  assign flush_busy      = flush_busy_q;
  assign flush_done      = flush_done_q;
  assign lru_way         = lru_way_q;
  assign flush_way       = flush_way_q;
  assign flush_set       = flush_set_q;
  assign load_data_bytes = load_data_bytes_q;
  assign load_data_lines = load_data_lines_q;
  assign load_tag        = load_tag_q;
  assign set_dirty       = set_dirty_q;
  assign write_dirty     = write_dirty_q;
  assign set_valid       = set_valid_q;
  assign write_valid     = write_valid_q;

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Directed bench for cache_ctrl_nway: a 4-way instance for CPU traffic and a
// 2-way/4-set instance for the flush walker, with scoreboard queues.
module tb_cache_ctrl_nway;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 4-way, 4-set, TIMEOUT=10 instance
  logic       rd, wr, hit, resp, flush;
  logic [1:0] hit_way, victim;
  logic [3:0] valid, dirty;
  logic       cmv, lru_load, mem_read, mem_write, dis, err, fbusy, fdone;
  logic [1:0] lru_way, fway, fset;
  logic [3:0] ldb, ldl, ltag, sd, wd, sv, wv;
  logic [41:0] all4;
  assign all4 = {cmv, lru_load, mem_read, mem_write, dis, err, fbusy, fdone,
                 lru_way, fway, fset, ldb, ldl, ltag, sd, wd, sv, wv};

  cache_ctrl_nway #(.WAYS(4), .SETS(4), .TIMEOUT(10)) u_dut4 (
    .clk(clk), .rst(rst), .cpu_read(rd), .cpu_write(wr), .hit(hit), .hit_way(hit_way),
    .is_valid(valid), .is_dirty(dirty), .victim_way(victim), .mem_resp(resp), .flush(flush),
    .cpu_mem_valid(cmv), .lru_load(lru_load), .mem_read(mem_read), .mem_write(mem_write),
    .data_in_select(dis), .error(err), .flush_busy(fbusy), .flush_done(fdone),
    .lru_way(lru_way), .flush_way(fway), .flush_set(fset), .load_data_bytes(ldb),
    .load_data_lines(ldl), .load_tag(ltag), .set_dirty(sd), .write_dirty(wd),
    .set_valid(sv), .write_valid(wv));

  // 2-way, 4-set instance driven only by flush; the bench models its dirty bits
  logic       resp2, flush2;
  logic [1:0] valid2, dirty2;
  logic       cmv2, lru_load2, mem_read2, mem_write2, dis2, err2, fbusy2, fdone2;
  logic [0:0] lru_way2, fway2;
  logic [1:0] fset2, ldb2, ldl2, ltag2, sd2, wd2, sv2, wv2;
  logic [1:0] dirty_arr [4];
  assign valid2 = 2'b11;
  assign dirty2 = dirty_arr[fset2];

  cache_ctrl_nway #(.WAYS(2), .SETS(4), .TIMEOUT(10)) u_dut2 (
    .clk(clk), .rst(rst), .cpu_read(1'b0), .cpu_write(1'b0), .hit(1'b0), .hit_way(1'b0),
    .is_valid(valid2), .is_dirty(dirty2), .victim_way(1'b0), .mem_resp(resp2), .flush(flush2),
    .cpu_mem_valid(cmv2), .lru_load(lru_load2), .mem_read(mem_read2), .mem_write(mem_write2),
    .data_in_select(dis2), .error(err2), .flush_busy(fbusy2), .flush_done(fdone2),
    .lru_way(lru_way2), .flush_way(fway2), .flush_set(fset2), .load_data_bytes(ldb2),
    .load_data_lines(ldl2), .load_tag(ltag2), .set_dirty(sd2), .write_dirty(wd2),
    .set_valid(sv2), .write_valid(wv2));

  typedef struct packed { logic [1:0] way; logic [3:0] bytes, sdirty, wdirty; } ack_t;
  typedef struct packed { logic [3:0] lines, tag, svalid, wvalid, wdirty, sdirty; logic sel; } inst_t;
  typedef struct packed { logic [1:0] set; logic way; } pos_t;
  ack_t  ack_q[$];
  inst_t inst_q[$];
  pos_t  pos_q[$];

  int tests = 0, fails = 0;
  int mw_bursts = 0, mr_bursts = 0, mr_cyc = 0, ack_cyc = 0, strobe_cyc = 0;
  int mw_bursts2 = 0, done_cyc2 = 0, bad2_cyc = 0;
  logic prev_mw = 1'b0, prev_mr = 1'b0, prev_mw2 = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply modelled array writes, then tally output activity.
  task automatic tick();
    logic [1:0] wd2_s, sd2_s, set_s;
    pos_t p;
    wd2_s = wd2; sd2_s = sd2; set_s = fset2;
    @(posedge clk); #1;
    for (int w = 0; w < 2; w++) if (wd2_s[w]) dirty_arr[set_s][w] = sd2_s[w];
    if (mem_write && !prev_mw) mw_bursts++;
    if (mem_read && !prev_mr) mr_bursts++;
    if (mem_read) mr_cyc++;
    if (cmv) ack_cyc++;
    if (|{ldb, ldl, ltag, sd, wd, sv, wv}) strobe_cyc++;
    prev_mw = mem_write;
    prev_mr = mem_read;
    if (mem_write2 && !prev_mw2) begin
      mw_bursts2++;
      check("flush_burst_expected", 64'(pos_q.size() != 0), 64'(1));
      if (pos_q.size() != 0) begin
        p = pos_q.pop_front();
        check("flush_burst_pos", 64'({fset2, fway2}), 64'(p));
      end
    end
    prev_mw2 = mem_write2;
    if (fdone2) done_cyc2++;
    if (|{cmv2, lru_load2, mem_read2, dis2, err2, lru_way2, ldb2, ldl2, ltag2, sv2, wv2}) bad2_cyc++;
  endtask

  task automatic wait_ack(input string tag);
    ack_t e, o;
    int n = 0;
    while (!cmv && n < 50) begin tick(); n++; end
    check({tag, "_ack_seen"}, 64'(cmv), 64'(1));
    e = ack_q.pop_front();
    o = '{way: lru_way, bytes: ldb, sdirty: sd, wdirty: wd};
    check({tag, "_ack_fields"}, 64'(o), 64'(e));
    check({tag, "_lru_load"}, 64'(lru_load), 64'(1));
    check({tag, "_ack_sel"}, 64'(dis), 64'(0));
  endtask

  task automatic wait_install(input string tag);
    inst_t e, o;
    int n = 0;
    while (ldl == 4'b0 && n < 50) begin tick(); n++; end
    e = inst_q.pop_front();
    o = '{lines: ldl, tag: ltag, svalid: sv, wvalid: wv, wdirty: wd, sdirty: sd, sel: dis};
    check({tag, "_install"}, 64'(o), 64'(e));
  endtask

  initial begin
    int mw0, mr0, mr_c0, s0, a0, mwc, n;
    rst = 1'b1;
    {rd, wr, hit, resp, flush, resp2, flush2} = '0;
    hit_way = '0; victim = '0; valid = '0; dirty = '0;
    for (int s = 0; s < 4; s++) dirty_arr[s] = 2'b00;
    #2 rst = 1'b0;
    #1 check("reset_outputs", 64'(all4), 64'(0));
    tick(); tick();
    rst = 1'b1;

    // stray mem_resp in IDLE is ignored
    resp = 1'b1; tick(); resp = 1'b0; tick();
    check("resp_in_idle", 64'(all4), 64'(0));

    // read hit on way 2
    mr0 = mr_bursts;
    rd = 1'b1; hit = 1'b1; hit_way = 2'd2; valid = 4'b0100;
    ack_q.push_back('{way: 2'd2, bytes: 4'b0, sdirty: 4'b0, wdirty: 4'b0});
    tick();
    check("hit_not_yet", 64'(cmv), 64'(0));
    tick();
    check("hit_latency", 64'(cmv), 64'(1));
    wait_ack("read_hit");
    rd = 1'b0; tick();
    check("ack_one_cycle", 64'(cmv), 64'(0));
    check("read_hit_no_memread", 64'(mr_bursts - mr0), 64'(0));

    // write miss, dirty victim way 1: write-back, fill, install, merge
    mw0 = mw_bursts; mr0 = mr_bursts;
    wr = 1'b1; hit = 1'b0; valid = 4'b1111; dirty = 4'b0010; victim = 2'd1;
    inst_q.push_back('{lines: 4'b0010, tag: 4'b0010, svalid: 4'b0010, wvalid: 4'b0010,
                       wdirty: 4'b0010, sdirty: 4'b0000, sel: 1'b1});
    ack_q.push_back('{way: 2'd1, bytes: 4'b0010, sdirty: 4'b0010, wdirty: 4'b0010});
    tick(); tick();
    check("wb_req_write", 64'({mem_write, mem_read}), 64'(2'b10));
    tick(); tick();
    check("wb_held", 64'(mem_write), 64'(1));
    resp = 1'b1; tick(); resp = 1'b0;
    check("fill_req_read", 64'({mem_write, mem_read}), 64'(2'b01));
    tick(); resp = 1'b1; tick(); resp = 1'b0;
    wait_install("write_miss");
    hit = 1'b1; hit_way = 2'd1;
    wait_ack("write_miss");
    wr = 1'b0; hit = 1'b0; tick();
    check("write_miss_wb_bursts", 64'(mw_bursts - mw0), 64'(1));
    check("write_miss_rd_bursts", 64'(mr_bursts - mr0), 64'(1));

    // read miss picks lowest invalid way 2, no write-back
    mw0 = mw_bursts;
    rd = 1'b1; valid = 4'b1011; dirty = 4'b1111; victim = 2'd0;
    inst_q.push_back('{lines: 4'b0100, tag: 4'b0100, svalid: 4'b0100, wvalid: 4'b0100,
                       wdirty: 4'b0100, sdirty: 4'b0000, sel: 1'b1});
    ack_q.push_back('{way: 2'd2, bytes: 4'b0, sdirty: 4'b0, wdirty: 4'b0});
    tick(); tick();
    check("read_miss_fill", 64'({mem_write, mem_read}), 64'(2'b01));
    tick(); resp = 1'b1; tick(); resp = 1'b0;
    wait_install("read_miss");
    hit = 1'b1; hit_way = 2'd2; valid = 4'b1111;
    wait_ack("read_miss");
    rd = 1'b0; hit = 1'b0; tick();
    check("read_miss_no_wb", 64'(mw_bursts - mw0), 64'(0));

    // read and write together behave as a write
    rd = 1'b1; wr = 1'b1; hit = 1'b1; hit_way = 2'd3; valid = 4'b1000;
    ack_q.push_back('{way: 2'd3, bytes: 4'b1000, sdirty: 4'b1000, wdirty: 4'b1000});
    wait_ack("rw_hit");
    rd = 1'b0; wr = 1'b0; hit = 1'b0; tick();

    // fill never answered: timeout after 10 wait cycles
    mr_c0 = mr_cyc; s0 = strobe_cyc; a0 = ack_cyc;
    rd = 1'b1; valid = 4'b1111; dirty = 4'b0000; victim = 2'd3;
    n = 0;
    while (!err && n < 60) begin tick(); n++; end
    check("timeout_error_seen", 64'(err), 64'(1));
    check("timeout_wait_cycles", 64'(mr_cyc - mr_c0), 64'(10));
    rd = 1'b0; tick();
    check("error_one_cycle", 64'(all4), 64'(0));
    check("error_no_strobes", 64'(strobe_cyc - s0), 64'(0));
    check("error_no_ack", 64'(ack_cyc - a0), 64'(0));

    // asynchronous reset during write-back, then a normal hit
    s0 = strobe_cyc;
    wr = 1'b1; valid = 4'b1111; dirty = 4'b0001; victim = 2'd0;
    tick(); tick();
    check("wb_before_reset", 64'(mem_write), 64'(1));
    tick();
    #2 rst = 1'b0;
    #1 check("reset_async_clear", 64'(all4), 64'(0));
    wr = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("reset_no_strobes", 64'(strobe_cyc - s0), 64'(0));
    rd = 1'b1; hit = 1'b1; hit_way = 2'd0; valid = 4'b0001;
    ack_q.push_back('{way: 2'd0, bytes: 4'b0, sdirty: 4'b0, wdirty: 4'b0});
    tick();
    check("post_reset_not_yet", 64'(cmv), 64'(0));
    tick();
    check("post_reset_latency", 64'(cmv), 64'(1));
    wait_ack("post_reset");
    rd = 1'b0; hit = 1'b0; tick();

    // flush of the 2-way cache: dirty at (1,1) and (3,0)
    dirty_arr[1] = 2'b10; dirty_arr[3] = 2'b01;
    pos_q.push_back('{set: 2'd1, way: 1'b1});
    pos_q.push_back('{set: 2'd3, way: 1'b0});
    flush2 = 1'b1; tick(); flush2 = 1'b0;
    mwc = 0; n = 0;
    while (!fdone2 && n < 300) begin
      tick(); n++;
      if (mem_write2) begin mwc++; resp2 = (mwc == 2); end
      else begin mwc = 0; resp2 = 1'b0; end
    end
    resp2 = 1'b0;
    check("flush_done_seen", 64'(fdone2), 64'(1));
    check("flush_busy_off_at_done", 64'(fbusy2), 64'(0));
    tick(); tick(); tick();
    check("flush_done_pulses", 64'(done_cyc2), 64'(1));
    check("flush_wb_bursts", 64'(mw_bursts2), 64'(2));
    check("flush_positions_left", 64'(pos_q.size()), 64'(0));
    check("flush_dirty_cleared", 64'({dirty_arr[0], dirty_arr[1], dirty_arr[2], dirty_arr[3]}), 64'(0));
    check("flush_no_cpu_strobes", 64'(bad2_cyc), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache_ctrl_nway.md
CACHE_CTRL_NWAY -- requirements
Module: cache_ctrl_nway

Interface
REQ-001 SHALL have parameters: WAYS, default 2, associativity (power of 2, 2..8); SETS, default 16, set count (power of 2); TIMEOUT, default 255, max cycles waiting on mem_resp; WAY_W = clog2(WAYS); SET_W = clog2(SETS).
REQ-002 SHALL have ports: clk  in  1  clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 cpu_read, cpu_write  in  1 each  CPU request levels, held until cpu_mem_valid.
REQ-005 hit  in  1  tag match in addressed set; hit_way  in  WAY_W  matching way.
REQ-006 is_valid, is_dirty  in  WAYS  per-way status bits of addressed set.
REQ-007 victim_way  in  WAY_W  LRU choice from replacement block; mem_resp  in  1  memory completion pulse.
REQ-008 flush  in  1  request write-back of every dirty line.
REQ-009 cpu_mem_valid, lru_load, mem_read, mem_write, data_in_select (1 = memory line, 0 = CPU bytes), error, flush_busy, flush_done  out  1 each.
REQ-010 lru_way, flush_way  out  WAY_W; flush_set  out  SET_W (index override when flush_busy=1).
REQ-011 load_data_bytes, load_data_lines, load_tag, set_dirty, write_dirty, set_valid, write_valid  out  WAYS  one-hot per-way strobes.

Function
REQ-012 States SHALL be IDLE, CHECK, WB_REQ, FILL_REQ, INSTALL, FL_SCAN, FL_WB, ERROR; all outputs default 0 in every state unless stated.
REQ-013 IDLE: flush -> FL_SCAN (flush_set=0, flush_way=0); else cpu_write or cpu_read -> CHECK, latching op type; else stay. flush has priority.
REQ-014 CHECK, hit and is_valid[hit_way]: cpu_mem_valid=1, lru_load=1, lru_way=hit_way, -> IDLE; hit latency = 2 cycles from request sampled in IDLE.
REQ-015 CHECK write hit additionally: load_data_bytes[hit_way]=1, data_in_select=0, write_dirty[hit_way]=1, set_dirty[hit_way]=1.
REQ-016 CHECK miss: latch vway = lowest-index way with is_valid=0, else victim_way; -> WB_REQ if is_valid[vway] and is_dirty[vway], else FILL_REQ.
REQ-017 WB_REQ: mem_write=1 held until mem_resp=1 sampled, then -> FILL_REQ.
REQ-018 FILL_REQ: mem_read=1 held until mem_resp=1 sampled, then -> INSTALL.
REQ-019 INSTALL (one cycle): data_in_select=1, load_data_lines[vway], load_tag[vway], write_valid/set_valid[vway]=1, write_dirty[vway]=1 with set_dirty[vway]=0; -> CHECK (re-check SHALL hit; write then merges per REQ-015).
REQ-020 FL_SCAN: flush_busy=1; if is_valid[flush_way] and is_dirty[flush_way] -> FL_WB, else advance.
REQ-021 FL_WB: flush_busy=1, mem_write=1 until mem_resp; on mem_resp write_dirty[flush_way]=1, set_dirty=0, then advance; valid bits unchanged.
REQ-022 Advance: flush_way+1; wrap to 0 increments flush_set; after set SETS-1 way WAYS-1, flush_done=1 for one cycle, -> IDLE.
REQ-023 Wait counter: cleared on entering WB_REQ/FILL_REQ/FL_WB, incremented each waiting cycle; reaching TIMEOUT without mem_resp -> ERROR.
REQ-024 ERROR: error=1 for exactly one cycle, -> IDLE; no strobes issued; request not acknowledged.
REQ-025 mem_resp outside a waiting state SHALL be ignored; cpu_read and cpu_write both high SHALL be treated as write.
REQ-026 flush asserted while not IDLE SHALL be ignored until IDLE (level re-sampled).

Reset
REQ-027 rst=0 SHALL asynchronously force IDLE, all outputs 0, vway, op latch, flush_set, flush_way, wait counter 0.
REQ-028 Reset mid-transaction SHALL abandon it with no strobe emitted; first request after release proceeds normally.

Verification
REQ-029 WAYS=4; read, hit=1, hit_way=2, is_valid=4'b0100 -> cycle 2: cpu_mem_valid=1, lru_way=2, no mem_read.
REQ-030 Write miss, is_valid=4'b1111, is_dirty=4'b0010, victim_way=1 -> mem_write until mem_resp, mem_read until mem_resp, INSTALL strobes way 1, then CHECK hit write with set_dirty[1]=1, cpu_mem_valid=1.
REQ-031 Read miss, is_valid=4'b1011 -> vway=2, no mem_write, load_data_lines[2]=1 with set_dirty[2]=0.
REQ-032 SETS=4, WAYS=2, dirty only at (set 1, way 1) and (set 3, way 0) -> exactly two mem_write bursts, flush_done one pulse after 8 positions.
REQ-033 FILL_REQ, mem_resp never asserted, TIMEOUT=10 -> error pulse after 10 wait cycles, then IDLE.
REQ-034 rst=0 during WB_REQ -> outputs 0 immediately (no clock edge); next read hit completes in 2 cycles.
